// File: rtl/ws2812_frame_arbiter_pkg.sv
// Shared types and constants for the WS2812 frame arbiter (package ws2812_pkg).
package ws2812_pkg;

  localparam int   BITS_PER_LED = 24;
  localparam logic SRC_PAT      = 1'b0;
  localparam logic SRC_HOST     = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BUSY = 2'd1,
    ST_SEND      = 2'd2,
    ST_GAP       = 2'd3
  } state_e;

endpackage

// File: rtl/ws2812_rr_arb2.sv
// Two-requester round-robin arbiter; the priority pointer only moves when a grant is issued.
module ws2812_rr_arb2
  import ws2812_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  // prio_q names the source that wins a tie (the one not granted last)
  logic prio_q, prio_d;

  always_comb begin
    gnt    = 2'b00;
    prio_d = prio_q;
    if (en) begin
      if (req == 2'b11) gnt[prio_q] = 1'b1;
      else              gnt         = req;
      if (|req) prio_d = gnt[SRC_PAT] ? SRC_HOST : SRC_PAT;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) prio_q <= SRC_PAT;
    else          prio_q <= prio_d;
  end

endmodule

// File: rtl/ws2812_frame_arbiter.sv
// Arbitrates pattern/host frames onto one WS2812 driver with start timeout and latch gap.
// Optional WS2812_HOST_LOCK_EN adds a host_lock input that masks pattern requests in IDLE.
//
// state        | meaning
// ST_IDLE      | waiting for a request, arbitration active
// ST_WAIT_BUSY | drv_start issued, waiting for drv_busy (timeout -> ST_GAP)
// ST_SEND      | driver shifting the frame
// ST_GAP       | post-frame latch gap, GAP_CYCLES long
module ws2812_frame_arbiter
  import ws2812_pkg::*;
#(
  parameter int NUM_LED       = 8,
  parameter int GAP_CYCLES    = 5000,
  parameter int START_TIMEOUT = 15
) (
  input  logic                            clk,
  input  logic                            reset_n,
`ifdef WS2812_HOST_LOCK_EN
  input  logic                            host_lock,
`endif
  input  logic                            req_pat,
  input  logic [NUM_LED*BITS_PER_LED-1:0] rgb_pat,
  input  logic                            req_host,
  input  logic [NUM_LED*BITS_PER_LED-1:0] rgb_host,
  output logic                            ack_pat,
  output logic                            ack_host,
  output logic                            drv_start,
  output logic [NUM_LED*BITS_PER_LED-1:0] drv_rgb_data,
  input  logic                            drv_busy,
  output logic                            busy,
  output logic                            frame_done,
  output logic                            start_err
);

  localparam int W     = NUM_LED * BITS_PER_LED;
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int TMO_W = (START_TIMEOUT < 1) ? 1 : $clog2(START_TIMEOUT + 1);

  state_e           state_q, state_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [W-1:0]     data_q, data_d;
  logic             drv_start_q, drv_start_d;
  logic             ack_pat_q, ack_pat_d;
  logic             ack_host_q, ack_host_d;
  logic             frame_done_q, frame_done_d;
  logic             start_err_q, start_err_d;
  logic [1:0]       req_vec;
  logic [1:0]       gnt;

`ifdef WS2812_HOST_LOCK_EN
  assign req_vec = {req_host, req_pat & ~host_lock};
`else
  assign req_vec = {req_host, req_pat};
`endif

  ws2812_rr_arb2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req_vec),
    .en      (state_q == ST_IDLE),
    .gnt     (gnt)
  );

  always_comb begin
    state_d      = state_q;
    tmo_cnt_d    = tmo_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    data_d       = data_q;
    drv_start_d  = 1'b0;
    ack_pat_d    = 1'b0;
    ack_host_d   = 1'b0;
    frame_done_d = 1'b0;
    start_err_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|gnt) begin
          state_d     = ST_WAIT_BUSY;
          tmo_cnt_d   = TMO_W'(START_TIMEOUT);
          drv_start_d = 1'b1;
          ack_pat_d   = gnt[SRC_PAT];
          ack_host_d  = gnt[SRC_HOST];
          data_d      = gnt[SRC_HOST] ? rgb_host : rgb_pat;
        end
      end
      ST_WAIT_BUSY: begin
        if (drv_busy) begin
          state_d   = ST_SEND;
          tmo_cnt_d = '0;
        end else if (tmo_cnt_q <= TMO_W'(1)) begin
          start_err_d = 1'b1;
          state_d     = ST_GAP;
          tmo_cnt_d   = '0;
          gap_cnt_d   = GAP_W'(GAP_CYCLES);
        end else begin
          tmo_cnt_d = tmo_cnt_q - 1'b1;
        end
      end
      ST_SEND: begin
        if (!drv_busy) begin
          frame_done_d = 1'b1;
          state_d      = ST_GAP;
          gap_cnt_d    = GAP_W'(GAP_CYCLES);
        end
      end
      ST_GAP: begin
        // count down to 1 and stop there, so the counter can never wrap
        if (gap_cnt_q <= GAP_W'(1)) begin
          state_d   = ST_IDLE;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      tmo_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      data_q       <= '0;
      drv_start_q  <= 1'b0;
      ack_pat_q    <= 1'b0;
      ack_host_q   <= 1'b0;
      frame_done_q <= 1'b0;
      start_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmo_cnt_q    <= tmo_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      data_q       <= data_d;
      drv_start_q  <= drv_start_d;
      ack_pat_q    <= ack_pat_d;
      ack_host_q   <= ack_host_d;
      frame_done_q <= frame_done_d;
      start_err_q  <= start_err_d;
    end
  end

  assign ack_pat      = ack_pat_q;
  assign ack_host     = ack_host_q;
  assign drv_start    = drv_start_q;
  assign drv_rgb_data = data_q;
  assign busy         = (state_q != ST_IDLE);
  assign frame_done   = frame_done_q;
  assign start_err    = start_err_q;

endmodule

// File: tb/tb_ws2812_frame_arbiter.sv
// Self-checking bench for ws2812_frame_arbiter: frame vector table plus scoreboard of expected grants.
module tb_ws2812_frame_arbiter;
  import ws2812_pkg::*;

  localparam int NUM_LED = 2;
  localparam int GAP     = 40;
  localparam int TMO     = 15;
  localparam int W       = NUM_LED * BITS_PER_LED;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         req_pat, req_host, drv_busy;
  logic [W-1:0] rgb_pat, rgb_host;
  logic         ack_pat, ack_host, drv_start, busy, frame_done, start_err;
  logic [W-1:0] drv_rgb_data;
`ifdef WS2812_HOST_LOCK_EN
  logic         host_lock;
`endif

  always #5 clk = ~clk;

  ws2812_frame_arbiter #(
    .NUM_LED       (NUM_LED),
    .GAP_CYCLES    (GAP),
    .START_TIMEOUT (TMO)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
`ifdef WS2812_HOST_LOCK_EN
    .host_lock    (host_lock),
`endif
    .req_pat      (req_pat),
    .rgb_pat      (rgb_pat),
    .req_host     (req_host),
    .rgb_host     (rgb_host),
    .ack_pat      (ack_pat),
    .ack_host     (ack_host),
    .drv_start    (drv_start),
    .drv_rgb_data (drv_rgb_data),
    .drv_busy     (drv_busy),
    .busy         (busy),
    .frame_done   (frame_done),
    .start_err    (start_err)
  );

  typedef struct {
    logic         src;
    logic [W-1:0] data;
  } exp_t;

  typedef struct {
    logic rp;
    logic rh;
    int   dly;
    int   len;
    logic exp_src;
  } vec_t;

  exp_t sb_q[$];
  exp_t mon_e;
  vec_t vecs[8];
  int   n_pass  = 0;
  int   n_total = 0;
  logic seen;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rnd();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[W-1:0];
  endfunction

  task automatic push_exp(input logic src);
    exp_t e;
    e.src  = src;
    e.data = src ? rgb_host : rgb_pat;
    sb_q.push_back(e);
  endtask

  // Drive requests in IDLE, expect drv_start on the next cycle, then drop them.
  task automatic grant(input logic rp, input logic rh, input logic src, input string tag);
    req_pat  = rp;
    req_host = rh;
    rgb_pat  = rnd();
    rgb_host = rnd();
    push_exp(src);
    tick();
    chk({tag, "_start"}, drv_start, 1'b1);
    chk({tag, "_busy"}, busy, 1'b1);
    req_pat  = 1'b0;
    req_host = 1'b0;
  endtask

  // Called in the drv_start cycle; plays the driver and checks through the end of the gap.
  // dly < 0 means the driver never answers.
  task automatic do_frame(input int dly, input int len, input bit pulse_host);
    logic [W-1:0] held;
    logic         s;
    held     = drv_rgb_data;
    rgb_pat  = rnd();
    rgb_host = rnd();
    s        = 1'b0;
    if (dly < 0) begin
      for (int i = 1; i < TMO; i++) begin
        tick();
        if (start_err | frame_done) s = 1'b1;
      end
      chk("no_early_err", s, 1'b0);
      tick();
      chk("start_err", start_err, 1'b1);
      chk("err_then_gap", busy, 1'b1);
      chk("err_no_done", frame_done, 1'b0);
    end else begin
      repeat (dly) tick();
      drv_busy = 1'b1;
      for (int i = 0; i < len; i++) begin
        if (pulse_host && i == 2) req_host = 1'b1;
        else if (pulse_host && i == 3) req_host = 1'b0;
        tick();
        if (start_err | frame_done) s = 1'b1;
      end
      chk("send_quiet", s, 1'b0);
      chk("data_stable", drv_rgb_data, held);
      drv_busy = 1'b0;
      tick();
      chk("frame_done", frame_done, 1'b1);
    end
    s = 1'b0;
    repeat (GAP - 1) begin
      tick();
      if (frame_done | start_err | drv_start) s = 1'b1;
    end
    chk("gap_quiet", s, 1'b0);
    chk("gap_busy_last", busy, 1'b1);
    tick();
    chk("gap_end_idle", busy, 1'b0);
  endtask

  // Scoreboard: every start/ack must match the oldest expected grant.
  always @(posedge clk) begin
    #1;
    if (ack_pat | ack_host | drv_start) begin
      chk("one_ack", ack_pat & ack_host, 1'b0);
      chk("start_with_ack", drv_start, ack_pat | ack_host);
      chk("ack_expected", sb_q.size() != 0, 1'b1);
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        chk("ack_src", ack_host, mon_e.src);
        chk("ack_data", drv_rgb_data, mon_e.data);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 1'b0,  3, 100, SRC_PAT};
    vecs[1] = '{1'b1, 1'b0,  0,   2, SRC_PAT};
    vecs[2] = '{1'b0, 1'b1,  1,   5, SRC_HOST};
    vecs[3] = '{1'b0, 1'b1,  2,   3, SRC_HOST};
    vecs[4] = '{1'b1, 1'b1,  1,   4, SRC_PAT};
    vecs[5] = '{1'b1, 1'b1,  1,   4, SRC_HOST};
    vecs[6] = '{1'b1, 1'b0, -1,   0, SRC_PAT};
    vecs[7] = '{1'b1, 1'b1, 14,   2, SRC_HOST};

    reset_n  = 1'b0;
    req_pat  = 1'b0;
    req_host = 1'b0;
    drv_busy = 1'b0;
    rgb_pat  = rnd();
    rgb_host = rnd();
`ifdef WS2812_HOST_LOCK_EN
    host_lock = 1'b0;
`endif
    repeat (3) tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_start", drv_start, 1'b0);
    chk("rst_acks", {ack_pat, ack_host}, 2'b00);
    chk("rst_done", frame_done, 1'b0);
    chk("rst_err", start_err, 1'b0);
    chk("rst_data", drv_rgb_data, '0);
    reset_n = 1'b1;
    tick();

    // Simultaneous requests after reset: pattern first, host pending wins after the gap.
    req_pat  = 1'b1;
    req_host = 1'b1;
    rgb_pat  = rnd();
    rgb_host = rnd();
    push_exp(SRC_PAT);
    tick();
    chk("s2_pat_start", drv_start, 1'b1);
    req_pat = 1'b0;
    do_frame(2, 10, 1'b0);
    push_exp(SRC_HOST);
    tick();
    chk("s2_host_start", drv_start, 1'b1);
    req_host = 1'b0;
    do_frame(1, 3, 1'b0);

    for (int i = 0; i < 8; i++) begin
      grant(vecs[i].rp, vecs[i].rh, vecs[i].exp_src, $sformatf("v%0d", i));
      do_frame(vecs[i].dly, vecs[i].len, 1'b0);
    end

    // One-cycle host request during SEND must vanish unacked.
    grant(1'b1, 1'b0, SRC_PAT, "pulse");
    do_frame(1, 10, 1'b1);
    seen = 1'b0;
    repeat (5) begin
      tick();
      if (ack_host | drv_start) seen = 1'b1;
    end
    chk("pulse_never_acked", seen, 1'b0);

    // Reset in the middle of SEND aborts silently.
    grant(1'b1, 1'b0, SRC_PAT, "rst_pre");
    drv_busy = 1'b1;
    repeat (4) tick();
    chk("rst_in_send", busy, 1'b1);
    reset_n = 1'b0;
    tick();
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_data", drv_rgb_data, '0);
    chk("mid_rst_pulses", {drv_start, ack_pat, ack_host, frame_done, start_err}, 5'b0);
    reset_n  = 1'b1;
    drv_busy = 1'b0;
    seen     = 1'b0;
    repeat (3) begin
      tick();
      if (frame_done | start_err | drv_start | busy) seen = 1'b1;
    end
    chk("rst_silent", seen, 1'b0);
    grant(1'b0, 1'b1, SRC_HOST, "post_rst");
    do_frame(1, 4, 1'b0);

`ifdef WS2812_HOST_LOCK_EN
    host_lock = 1'b1;
    req_pat   = 1'b1;
    rgb_pat   = rnd();
    seen      = 1'b0;
    repeat (4) begin
      tick();
      if (ack_pat | drv_start) seen = 1'b1;
    end
    chk("lock_blocks_pat", seen, 1'b0);
    req_host = 1'b1;
    rgb_host = rnd();
    push_exp(SRC_HOST);
    tick();
    chk("lock_host_start", drv_start, 1'b1);
    req_host = 1'b0;
    do_frame(1, 3, 1'b0);
    push_exp(SRC_PAT);
    host_lock = 1'b0;
    tick();
    chk("unlock_pat_start", drv_start, 1'b1);
    req_pat = 1'b0;
    do_frame(1, 3, 1'b0);
`endif

    repeat (3) tick();
    chk("sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ws2812_frame_arbiter.md
WS2812_FRAME_ARBITER -- requirements
Module: ws2812_frame_arbiter

Interface
REQ-001 Parameter NUM_LED, default 8: LEDs per frame; frame width is NUM_LED*24 bits.
REQ-002 Parameter GAP_CYCLES, default 5000: post-frame latch gap in clk cycles; legal range is 1 or more.
REQ-003 Parameter START_TIMEOUT, default 15: cycles to wait for drv_busy after drv_start.
REQ-004 clk  in  1  sole clock; all logic rising-edge.
REQ-005 reset_n  in  1  synchronous, active-low reset.
REQ-006 req_pat  in  1  pattern-source frame request, level.
REQ-007 rgb_pat  in  NUM_LED*24  pattern-source frame data.
REQ-008 req_host  in  1  host (UART) frame request, level.
REQ-009 rgb_host  in  NUM_LED*24  host frame data.
REQ-010 ack_pat / ack_host  out  1 each  one-cycle pulse: that source's data has been latched.
REQ-011 drv_start  out  1  one-cycle start pulse to the WS2812 driver.
REQ-012 drv_rgb_data  out  NUM_LED*24  registered frame data to the driver.
REQ-013 drv_busy  in  1  driver is shifting a frame.
REQ-014 busy  out  1  high whenever state is not IDLE.
REQ-015 frame_done  out  1  one-cycle pulse when the driver finishes a frame.
REQ-016 start_err  out  1  one-cycle pulse on start timeout.

Function
REQ-017 The FSM SHALL have the states IDLE, WAIT_BUSY, SEND and GAP.
REQ-018 IDLE: if any request is sampled high at edge N, then in cycle N+1 drv_rgb_data SHALL hold the winner's data, drv_start and the winner's ack SHALL be high, and state SHALL be WAIT_BUSY.
REQ-019 Arbitration SHALL be round-robin: on simultaneous requests, the source not granted last wins; the rr pointer updates only on a grant.
REQ-020 A lone request SHALL win regardless of the pointer.
REQ-021 WAIT_BUSY: drv_busy=1 SHALL move the FSM to SEND; if START_TIMEOUT cycles elapse without drv_busy, start_err SHALL pulse once and the FSM SHALL enter GAP.
REQ-022 SEND: drv_busy=0 SHALL pulse frame_done and move the FSM to GAP.
REQ-023 GAP SHALL last exactly GAP_CYCLES cycles, then the FSM SHALL return to IDLE.
REQ-024 Requests asserted outside IDLE SHALL stay pending, without ack, until the next IDLE evaluation.
REQ-025 drv_rgb_data SHALL remain stable from drv_start until the next grant.
REQ-026 A request dropped before being sampled in IDLE SHALL never be acked.
REQ-027 A request still high in the ack cycle SHALL NOT be regranted until the FSM next returns to IDLE.
REQ-028 At most one ack SHALL be high in any cycle.
REQ-029 The gap counter SHALL be sized to clog2(GAP_CYCLES+1) bits and SHALL saturate, never wrap.

Reset
REQ-030 While reset_n=0 at an edge, the FSM SHALL go to IDLE; all pulses, busy and drv_rgb_data SHALL be 0; counters SHALL be 0; the rr pointer SHALL favour pattern.
REQ-031 A reset mid-frame SHALL abort silently, with no frame_done, start_err or reissued drv_start.

Configuration
REQ-032 With WS2812_HOST_LOCK_EN defined, an input port host_lock (1 bit) SHALL exist.
REQ-033 When host_lock=1, req_pat SHALL be ignored in IDLE; host_lock SHALL NOT abort a frame in progress.
REQ-034 Without WS2812_HOST_LOCK_EN, the host_lock port SHALL be absent and arbitration SHALL be pure round-robin.

Structure
REQ-035 Package ws2812_pkg SHALL hold the FSM state enum, BITS_PER_LED=24 and the source IDs SRC_PAT=0 and SRC_HOST=1.
REQ-036 The arbitration logic SHALL be a sub-module ws2812_rr_arb2 (2 requests, pointer, grant vector); the FSM, counters and data register SHALL stay in the top module.

Verification
REQ-037 The bench SHALL cover these scenarios:
- req_pat only, drv_busy high 3 cycles after start, low 100 cycles later -> ack_pat and drv_start in the same cycle; frame_done after drv_busy falls; busy low after GAP_CYCLES.
- req_pat and req_host asserted in the same cycle after reset -> pat granted first; host granted after GAP without re-request.
- drv_busy never asserted, START_TIMEOUT=15 -> start_err 15 cycles after drv_start; FSM then in GAP; no frame_done.
- req_host pulsed one cycle during SEND, then dropped -> no ack_host ever.
- reset_n low during SEND -> next cycle all outputs 0, state IDLE; a subsequent req_host is granted normally.
- WS2812_HOST_LOCK_EN with host_lock=1 and req_pat high -> no ack_pat; req_host granted; ack_pat follows once host_lock=0.
